// File: rtl/multicycle_control_fsm_pkg.sv
// multicycle_control_fsm_pkg
// Shared definitions for the multi-cycle RV32I control FSM: state encoding,
// ALU operand-B select codes, ALU-control mode constants and RV32I major
// opcodes, plus a helper that tells whether an opcode is one the core executes.
package multicycle_control_fsm_pkg;

   typedef enum logic [3:0] {
      StInit = 4'd0,
      StIf   = 4'd1,
      StId   = 4'd2,
      StEx   = 4'd3,
      StMem  = 4'd4,
      StWb   = 4'd5,
      StPc4  = 4'd6,
      StBr   = 4'd7,
      StHalt = 4'd8
   } state_e;

   // ALU operand B select
   localparam logic [1:0] ALU_B_RS2  = 2'b00;
   localparam logic [1:0] ALU_B_FOUR = 2'b01;
   localparam logic [1:0] ALU_B_IMM  = 2'b10;

   // ALU control unit mode
   localparam logic ALUCTRL_ADD    = 1'b0;
   localparam logic ALUCTRL_DECODE = 1'b1;

   // RV32I major opcodes
   localparam logic [6:0] OPC_ARITH     = 7'b0110011;
   localparam logic [6:0] OPC_ARITH_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LOAD      = 7'b0000011;
   localparam logic [6:0] OPC_STORE     = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
   localparam logic [6:0] OPC_JAL       = 7'b1101111;
   localparam logic [6:0] OPC_JALR      = 7'b1100111;
   localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

   // Opcodes that take the EX path; everything else retires as a NOP.
   function automatic logic takes_ex(input logic [6:0] opc);
      return (opc == OPC_ARITH) || (opc == OPC_ARITH_IMM) || (opc == OPC_LOAD) ||
             (opc == OPC_STORE) || (opc == OPC_BRANCH) || (opc == OPC_JAL) ||
             (opc == OPC_JALR);
   endfunction

endpackage

// File: rtl/multicycle_control_fsm_perf_counter.sv
// multicycle_control_fsm_perf_counter
// Free-running wrap-around counter with enable and synchronous clear.
// Ports:
//   clk    core clock
//   reset  asynchronous active-low reset (clears the count)
//   en     count enable
//   clr    synchronous clear (has priority over en)
//   count  current count value
module multicycle_control_fsm_perf_counter #(
   parameter int unsigned Width = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             clr,
   output logic [Width-1:0] count
);

   logic [Width-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (en) begin
         count_d = count_q + Width'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm
// Main control FSM of the multi-cycle RV32I core. Walks each instruction
// through IF/ID/EX/MEM/WB (plus PC4 and BR PC-update states), drives datapath
// enables and mux selects, waits on mem_ready for memory accesses and halts on
// a qualifying ECALL.
// Optional build macro: MULTICYCLE_PERF_CNT_EN adds cycle/retire counters.
// Ports:
//   clk, reset        clock, asynchronous active-low reset
//   opcode            IR[6:0]
//   mem_ready         memory finished the current access this cycle
//   alu_bcond         branch compare result (used in EX)
//   ecall_halt        x17 == 10 (used in ID)
//   pc_write .. alu_ctrl_op  datapath controls
//   retire            one-cycle pulse when an instruction completes
//   is_halted         core halted
//   cycle_count, retire_count  (macro only) performance counters
module multicycle_control_fsm
   import multicycle_control_fsm_pkg::*;
#(
   parameter int unsigned CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [6:0]       opcode,
   input  logic             mem_ready,
   input  logic             alu_bcond,
   input  logic             ecall_halt,
   output logic             pc_write,
   output logic             pc_source,
   output logic             i_or_d,
   output logic             mem_read,
   output logic             mem_write,
   output logic             ir_write,
   output logic             mem_to_reg,
   output logic             reg_write,
   output logic             aluout_write,
   output logic             alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic             alu_ctrl_op,
   output logic             retire,
   output logic             is_halted
`ifdef MULTICYCLE_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0] cycle_count,
   output logic [CNT_W-1:0] retire_count
`endif
);

   state_e state_q, state_d;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= StInit;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StInit: state_d = StIf;
         StIf: begin
            if (mem_ready) state_d = StId;
         end
         StId: begin
            if (opcode == OPC_SYSTEM) begin
               state_d = ecall_halt ? StHalt : StPc4;
            end else if (takes_ex(opcode)) begin
               state_d = StEx;
            end else begin
               state_d = StPc4;
            end
         end
         StEx: begin
            case (opcode)
               OPC_ARITH, OPC_ARITH_IMM, OPC_JAL, OPC_JALR: state_d = StWb;
               OPC_LOAD, OPC_STORE:                         state_d = StMem;
               OPC_BRANCH: state_d = alu_bcond ? StBr : StPc4;
               default:    state_d = StPc4;
            endcase
         end
         StMem: begin
            if (mem_ready) state_d = (opcode == OPC_LOAD) ? StWb : StPc4;
         end
         StWb, StPc4, StBr: state_d = StIf;
         StHalt:            state_d = StHalt;
         default:           state_d = StInit;
      endcase
   end

   always_comb begin
      pc_write     = 1'b0;
      pc_source    = 1'b0;
      i_or_d       = 1'b0;
      mem_read     = 1'b0;
      mem_write    = 1'b0;
      ir_write     = 1'b0;
      mem_to_reg   = 1'b0;
      reg_write    = 1'b0;
      aluout_write = 1'b0;
      alu_src_a    = 1'b0;
      alu_src_b    = ALU_B_RS2;
      alu_ctrl_op  = ALUCTRL_ADD;
      retire       = 1'b0;
      is_halted    = 1'b0;
      unique case (state_q)
         StIf: begin
            mem_read = 1'b1;
            ir_write = mem_ready;
         end
         StId: begin
            // Branch target PC+imm is parked in ALUOut for BR.
            alu_src_b    = ALU_B_IMM;
            aluout_write = 1'b1;
         end
         StEx: begin
            case (opcode)
               OPC_ARITH: begin
                  alu_src_a    = 1'b1;
                  alu_ctrl_op  = ALUCTRL_DECODE;
                  aluout_write = 1'b1;
               end
               OPC_ARITH_IMM, OPC_LOAD, OPC_STORE: begin
                  alu_src_a    = 1'b1;
                  alu_src_b    = ALU_B_IMM;
                  alu_ctrl_op  = ALUCTRL_DECODE;
                  aluout_write = 1'b1;
               end
               OPC_BRANCH: begin
                  // Compare only; ALUOut keeps the target from ID.
                  alu_src_a   = 1'b1;
                  alu_ctrl_op = ALUCTRL_DECODE;
               end
               OPC_JAL, OPC_JALR: begin
                  // Link value PC+4.
                  alu_src_b    = ALU_B_FOUR;
                  aluout_write = 1'b1;
               end
               default: ;
            endcase
         end
         StMem: begin
            i_or_d = 1'b1;
            if (opcode == OPC_LOAD) begin
               mem_read = 1'b1;
               ir_write = mem_ready;
            end
            if (opcode == OPC_STORE) mem_write = 1'b1;
         end
         StWb: begin
            reg_write  = 1'b1;
            mem_to_reg = (opcode == OPC_LOAD);
            pc_write   = 1'b1;
            retire     = 1'b1;
            case (opcode)
               OPC_JAL: alu_src_b = ALU_B_IMM;
               OPC_JALR: begin
                  alu_src_a = 1'b1;
                  alu_src_b = ALU_B_IMM;
               end
               default: alu_src_b = ALU_B_FOUR;
            endcase
         end
         StPc4: begin
            pc_write  = 1'b1;
            alu_src_b = ALU_B_FOUR;
            retire    = 1'b1;
         end
         StBr: begin
            pc_write  = 1'b1;
            pc_source = 1'b1;
            retire    = 1'b1;
         end
         StHalt: is_halted = 1'b1;
         default: ;
      endcase
   end

`ifdef MULTICYCLE_PERF_CNT_EN
   logic core_active;
   assign core_active = (state_q != StInit) && (state_q != StHalt);

   multicycle_control_fsm_perf_counter #(
      .Width (CNT_W)
   ) u_cycle_cnt (
      .clk   (clk),
      .reset (reset),
      .en    (core_active),
      .clr   (1'b0),
      .count (cycle_count)
   );

   multicycle_control_fsm_perf_counter #(
      .Width (CNT_W)
   ) u_retire_cnt (
      .clk   (clk),
      .reset (reset),
      .en    (retire),
      .clr   (1'b0),
      .count (retire_count)
   );
`endif

endmodule
